// File: rtl/prog_mem_arbiter.sv
// Arbitrates the single program-memory read port among NUM_CORES instruction fetchers.
// Define PROG_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority instead of round-robin.
module prog_mem_arbiter #(
   parameter int NUM_CORES  = 2,
   parameter int ADDR_BITS  = 8,
   parameter int INSTR_BITS = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_CORES-1:0]            fetcher_read_valid,
   input  logic [NUM_CORES*ADDR_BITS-1:0]  fetcher_read_address,
   output logic [NUM_CORES-1:0]            fetcher_read_ready,
   output logic [NUM_CORES*INSTR_BITS-1:0] fetcher_read_data,
   output logic                            mem_read_valid,
   output logic [ADDR_BITS-1:0]            mem_read_address,
   input  logic                            mem_read_ready,
   input  logic [INSTR_BITS-1:0]           mem_read_data,
   output logic                            busy
);

   localparam int          WB   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int unsigned NC_U = NUM_CORES;

   typedef enum logic [1:0] {IDLE, FETCH, RETURN, RELEASE} state_t;

   state_t               state;
   logic [WB-1:0]        win;
   logic [WB-1:0]        pick;
   logic                 pick_found;
   logic [ADDR_BITS-1:0] addr_q;
   logic [ADDR_BITS-1:0] pick_addr;
   logic [NUM_CORES-1:0] shifted;
   logic [NUM_CORES-1:0] win_vec;
   logic                 win_valid;
   int unsigned          cand;
`ifndef PROG_ARB_FIXED_PRIORITY_EN
   logic [WB-1:0]        rr_ptr;
`endif

   // Scan candidates starting at the priority origin; first requester found wins.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      cand       = 0;
      shifted    = '0;
      for (int unsigned k = 0; k < NC_U; k++) begin
`ifdef PROG_ARB_FIXED_PRIORITY_EN
         cand = k;
`else
         cand = (32'(rr_ptr) + k) % NC_U;
`endif
         shifted = fetcher_read_valid >> cand;
         if (!pick_found && shifted[0]) begin
            pick_found = 1'b1;
            pick       = WB'(cand);
         end
      end
   end

   always_comb begin
      pick_addr = '0;
      for (int unsigned i = 0; i < NC_U; i++) begin
         if (WB'(i) == pick) pick_addr = fetcher_read_address[i*ADDR_BITS +: ADDR_BITS];
      end
      win_vec   = fetcher_read_valid >> win;
      win_valid = win_vec[0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= IDLE;
         win                <= '0;
         addr_q             <= '0;
         mem_read_valid     <= 1'b0;
         fetcher_read_ready <= '0;
         fetcher_read_data  <= '0;
`ifndef PROG_ARB_FIXED_PRIORITY_EN
         rr_ptr             <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  win            <= pick;
                  addr_q         <= pick_addr;
                  mem_read_valid <= 1'b1;
                  state          <= FETCH;
               end
            end
            FETCH: begin
               if (mem_read_ready) begin
                  mem_read_valid <= 1'b0;
                  for (int unsigned i = 0; i < NC_U; i++) begin
                     if (WB'(i) == win) begin
                        fetcher_read_data[i*INSTR_BITS +: INSTR_BITS] <= mem_read_data;
                        fetcher_read_ready[i]                         <= 1'b1;
                     end
                  end
                  state <= RETURN;
               end
            end
            RETURN: begin
               fetcher_read_ready <= '0;
`ifndef PROG_ARB_FIXED_PRIORITY_EN
               rr_ptr             <= WB'((32'(win) + 1) % NC_U);
`endif
               state              <= RELEASE;
            end
            RELEASE: begin
               // Hold off re-arbitration until the served core lets go of its request.
               if (!win_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_read_address = addr_q;
   assign busy             = (state != IDLE);

endmodule
